tetris_move_arbiter: RTL and testbench
======================================

// Module: tetris_move_arbiter
// PURPOSE
// - Turns four synchronised button levels (down/left/right/rotate) into one stream of move commands for the game core.
// - Provides first-press issue, delayed auto-repeat (DAS/ARR) and fixed-priority sharing of the single move port.
// - Uses a valid/ready handshake; the game core drops ready while it is not in the FALLING state.
// - Sits between the button synchronisers and the game-logic block.
// PARAMETERS
// - DAS_DELAY   16  ticks a left/right press is held before auto-repeat starts (>=1)
// - ARR_PERIOD  4   ticks between left/right auto-repeat requests (>=1)
// - DROP_PERIOD 2   ticks between soft-drop repeat requests while down is held (>=1)
// - CNT_W       5   width of the repeat counters; must hold max(DAS_DELAY, ARR_PERIOD, DROP_PERIOD)
// PORTS
// - gm_clk     in   1   game clock
// - gm_rst_n   in   1   asynchronous, active-low reset
// - tick       in   1   one-cycle frame strobe; all repeat counters advance only on tick
// - btn_down   in   1   down button level
// - btn_left   in   1   left button level
// - btn_right  in   1   right button level
// - btn_rott   in   1   rotate button level
// - cmd_ready  in   1   game core accepts a command this cycle
// - cmd_valid  out  1   command available
// - cmd_code   out  2   0=DOWN, 1=LEFT, 2=RIGHT, 3=ROTATE
// - grant_cnt  out  16  count of accepted commands (ARB_STATS_EN only)
// BEHAVIOUR
// - Reset: cmd_valid=0, cmd_code=0, grant_cnt=0, all pending bits=0, all repeat FSMs in IDLE, all counters=0.
// - Rising edge (level=1, previous level=0) on any button sets that button's pending bit in the same cycle.
// - Pending bits are sticky: a release does not clear a pending first press, so taps are never lost.
// - Left/right repeat FSM, one per button:
//   - IDLE -> DELAY on rising edge; counter loaded to DAS_DELAY.
//   - DELAY: counter decrements on tick; at 0 -> REPEAT, set pending, load ARR_PERIOD.
//   - REPEAT: on tick, decrement; at 0 set pending and reload ARR_PERIOD.
//   - Any state -> IDLE when the level is 0. A repeat-generated pending bit is cleared on release.
// - Down FSM: IDLE -> REPEAT on rising edge, with DROP_PERIOD reload; no DAS stage.
// - Rotate FSM: edge only, never repeats.
// - Left and right held together:
//   - The most recently pressed button repeats; the other FSM is forced to IDLE and its pending bit is cleared.
//   - If both rise in the same cycle, left wins.
// - Arbiter: when cmd_valid=0 and any pending bit is set, the next cycle raises cmd_valid.
//   - Priority: ROTATE > LEFT > RIGHT > DOWN.
//   - The granted pending bit is cleared at grant, so latency from rising edge to cmd_valid is 1 cycle.
// - Handshake:
//   - While cmd_valid=1 and cmd_ready=0, cmd_code is held stable and new requests accumulate as pending bits.
//   - Transfer happens on the cycle where cmd_valid=1 and cmd_ready=1.
//   - After a transfer, cmd_valid drops for at least 1 cycle before the next grant (at most 1 command per 2 cycles).
// - Multiple repeat events for one button while a command is outstanding coalesce into one pending bit.
// - A tick coinciding with a rising edge: the edge load wins and the tick is ignored by that FSM.
// - Counters never wrap: they reload on reaching 0 and idle at 0 in IDLE.
// - Reset mid-handshake: cmd_valid drops immediately (asynchronously); the pending command is discarded.
// CONFIGURATION
// - ARB_STATS_EN defined:
//   - grant_cnt increments on every transfer and saturates at 16'hFFFF.
//   - It is cleared only by gm_rst_n.
// - ARB_STATS_EN undefined: grant_cnt is tied to 16'h0000 and no counter flops are instantiated.
// TESTING
// - Parameters at defaults, cmd_ready=1, tick every 4 cycles.
// - Left held for 40 ticks -> 1 LEFT at press, then LEFT at tick 16, 20, 24, 28, 32, 36, 40 (8 total).
// - Rotate, left and down rise in the same cycle with cmd_ready=1:
//   - Required order: ROTATE, LEFT, DOWN on successive grants.
//   - Each grant is separated by one idle cycle.
// - cmd_ready=0 for 50 cycles with left held past DAS:
//   - cmd_code stays at the first LEFT.
//   - Exactly one extra LEFT is delivered after ready returns.
// - Left held, then right pressed at tick 10:
//   - LEFT repeats stop; RIGHT is issued immediately.
//   - RIGHT repeats start 16 ticks later.
// - gm_rst_n pulled low while cmd_valid=1 and cmd_ready=0:
//   - cmd_valid=0 within the same cycle; no command is issued after release while buttons are 0.
// - ARB_STATS_EN defined: after 5 accepted commands, grant_cnt=5; with the internal count forced to 16'hFFFF, one more transfer leaves it at 16'hFFFF.

Source files
------------

// File: rtl/tetris_move_arbiter.sv
// rtl/tetris_move_arbiter.sv - button levels to one move-command stream with DAS/ARR repeat and fixed priority
// ARB_STATS_EN adds a saturating grant_cnt of accepted commands.
module tetris_move_arbiter #(
  parameter int DAS_DELAY   = 16,
  parameter int ARR_PERIOD  = 4,
  parameter int DROP_PERIOD = 2,
  parameter int CNT_W       = 5
) (
  input  logic        gm_clk,
  input  logic        gm_rst_n,
  input  logic        tick,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rott,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [1:0]  cmd_code,
  output logic [15:0] grant_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  typedef struct packed {
    rep_state_e       st;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic             from_rep;
  } rep_t;

  localparam logic [CNT_W-1:0] DAS_LD  = CNT_W'(DAS_DELAY);
  localparam logic [CNT_W-1:0] ARR_LD  = CNT_W'(ARR_PERIOD);
  localparam logic [CNT_W-1:0] DROP_LD = CNT_W'(DROP_PERIOD);

  logic [3:0] btn_q;
  logic [3:0] btn_now;
  logic [3:0] rise;
  rep_t       down_q, left_q, right_q;
  rep_t       down_n, left_n, right_n;
  logic       rott_q, rott_n;
  logic       valid_n;
  logic [1:0] code_n;

  // from_rep marks a pending bit created by auto-repeat, which a release may discard;
  // a pending first press stays sticky so short taps are never lost.
  function automatic rep_t rep_step(
    input rep_t             cur,
    input logic             lvl,
    input logic             rise_i,
    input logic             kill,
    input logic             tk,
    input logic [CNT_W-1:0] first_ld,
    input logic [CNT_W-1:0] rpt_ld,
    input rep_state_e       first_st
  );
    rep_t nxt;
    nxt = cur;
    if (kill) begin
      nxt = '0;
    end else if (!lvl) begin
      nxt.st  = ST_IDLE;
      nxt.cnt = '0;
      if (cur.from_rep) begin
        nxt.pend     = 1'b0;
        nxt.from_rep = 1'b0;
      end
    end else if (rise_i) begin
      nxt.st       = first_st;
      nxt.cnt      = first_ld;
      nxt.pend     = 1'b1;
      nxt.from_rep = 1'b0;
    end else if (tk && cur.st != ST_IDLE) begin
      if (cur.cnt <= CNT_W'(1)) begin
        nxt.st       = ST_REPEAT;
        nxt.cnt      = rpt_ld;
        nxt.from_rep = cur.from_rep | ~cur.pend;
        nxt.pend     = 1'b1;
      end else begin
        nxt.cnt = cur.cnt - 1'b1;
      end
    end
    return nxt;
  endfunction

  always_comb begin
    btn_now = {btn_rott, btn_right, btn_left, btn_down};
    rise    = btn_now & ~btn_q;
    // Newest of left/right owns the repeat; a simultaneous press goes to left.
    down_n  = rep_step(down_q, btn_down, rise[0], 1'b0, tick, DROP_LD, DROP_LD, ST_REPEAT);
    left_n  = rep_step(left_q, btn_left, rise[1], rise[2] & ~rise[1], tick, DAS_LD, ARR_LD, ST_DELAY);
    right_n = rep_step(right_q, btn_right, rise[2], rise[1], tick, DAS_LD, ARR_LD, ST_DELAY);
    rott_n  = rott_q | rise[3];
    valid_n = cmd_valid & ~cmd_ready;
    code_n  = cmd_code;
    if (!cmd_valid) begin
      if (rott_n) begin
        valid_n = 1'b1;
        code_n  = 2'd3;
        rott_n  = 1'b0;
      end else if (left_n.pend) begin
        valid_n         = 1'b1;
        code_n          = 2'd1;
        left_n.pend     = 1'b0;
        left_n.from_rep = 1'b0;
      end else if (right_n.pend) begin
        valid_n          = 1'b1;
        code_n           = 2'd2;
        right_n.pend     = 1'b0;
        right_n.from_rep = 1'b0;
      end else if (down_n.pend) begin
        valid_n         = 1'b1;
        code_n          = 2'd0;
        down_n.pend     = 1'b0;
        down_n.from_rep = 1'b0;
      end
    end
  end

  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      btn_q     <= '0;
      down_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      rott_q    <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_code  <= 2'd0;
    end else begin
      btn_q     <= btn_now;
      down_q    <= down_n;
      left_q    <= left_n;
      right_q   <= right_n;
      rott_q    <= rott_n;
      cmd_valid <= valid_n;
      cmd_code  <= code_n;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] grant_q;

  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      grant_q <= '0;
    end else if (cmd_valid && cmd_ready && grant_q != 16'hFFFF) begin
      grant_q <= grant_q + 16'd1;
    end
  end

  assign grant_cnt = grant_q;
`else
  assign grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tetris_move_arbiter.sv
// tb/tb_tetris_move_arbiter.sv - directed vector and sequence bench for tetris_move_arbiter
module tb_tetris_move_arbiter;

  logic        gm_clk = 1'b0;
  logic        gm_rst_n;
  logic        tick;
  logic        btn_down, btn_left, btn_right, btn_rott;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [1:0]  cmd_code;
  logic [15:0] grant_cnt;

  tetris_move_arbiter dut (
    .gm_clk    (gm_clk),
    .gm_rst_n  (gm_rst_n),
    .tick      (tick),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_rott  (btn_rott),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .grant_cnt (grant_cnt)
  );

  always #5 gm_clk = ~gm_clk;

  typedef struct {
    logic [3:0] btns;
    int         exp_code;
    int         exp_n;
  } vec_t;

  vec_t vecs [8];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   phase = 0;
  int   tick_cnt = 0;
  int   xfer_total = 0;
  bit   tick_en = 1'b0;
  int   rec_code [$];
  int   rec_tick [$];
  int   rec_cyc [$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btns(input logic [3:0] b);
    {btn_rott, btn_right, btn_left, btn_down} = b;
  endtask

  task automatic clear_recs();
    rec_code.delete();
    rec_tick.delete();
    rec_cyc.delete();
  endtask

  // Called at negedge+2; samples at negedge+3, posedge follows at negedge+5.
  task automatic cycle();
    tick  = tick_en && (phase == 0);
    phase = (phase + 1) % 4;
    #1;
    if (cmd_valid && cmd_ready) begin
      rec_code.push_back(int'(cmd_code));
      rec_tick.push_back(tick_cnt);
      rec_cyc.push_back(cyc);
      xfer_total++;
    end
    if (tick) tick_cnt++;
    cyc++;
    @(negedge gm_clk);
    #2;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_phase(input int p);
    for (int k = 0; k < 8 && phase != p; k++) cycle();
  endtask

  task automatic hold_until_rel(input int base, input int rel);
    for (int k = 0; k < 4 * rel + 16 && (tick_cnt - base) < rel; k++) cycle();
    check("tick_budget", tick_cnt - base, rel);
  endtask

  int exp_t40 [8] = '{0, 16, 20, 24, 28, 32, 36, 40};
  int exp_lr_code [4] = '{1, 2, 2, 2};
  int exp_lr_tick [4] = '{0, 10, 26, 30};

  initial begin
    int base;
    int c0;
    int bad;

    vecs[0] = '{4'b0001, 0, 1};
    vecs[1] = '{4'b0010, 1, 1};
    vecs[2] = '{4'b0100, 2, 1};
    vecs[3] = '{4'b1000, 3, 1};
    vecs[4] = '{4'b0110, 1, 1};
    vecs[5] = '{4'b0101, 2, 2};
    vecs[6] = '{4'b1111, 3, 3};
    vecs[7] = '{4'b1001, 3, 2};

    gm_rst_n  = 1'b0;
    tick      = 1'b0;
    cmd_ready = 1'b1;
    set_btns(4'b0000);
    @(negedge gm_clk);
    #2;
    cycles(3);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_code", cmd_code, 0);
    check("rst_grant_cnt", grant_cnt, 0);
    gm_rst_n = 1'b1;
    cycles(2);

    // Single-edge vectors, ticks off: first grant one cycle after the edge.
    tick_en = 1'b0;
    for (int v = 0; v < 8; v++) begin
      clear_recs();
      set_btns(vecs[v].btns);
      c0 = cyc;
      cycles(8);
      set_btns(4'b0000);
      cycles(4);
      check($sformatf("vec%0d_count", v), rec_code.size(), vecs[v].exp_n);
      check($sformatf("vec%0d_code", v), rec_code.size() > 0 ? rec_code[0] : -1, vecs[v].exp_code);
      check($sformatf("vec%0d_latency", v), rec_cyc.size() > 0 ? rec_cyc[0] - c0 : -1, 1);
    end

    // Tap of left while rotate is stalled: the tap must survive the release.
    clear_recs();
    cmd_ready = 1'b0;
    set_btns(4'b1000);
    cycle();
    set_btns(4'b0010);
    cycle();
    set_btns(4'b0000);
    cycles(4);
    check("tap_held_valid", cmd_valid, 1);
    check("tap_held_code", cmd_code, 3);
    cmd_ready = 1'b1;
    cycles(6);
    check("tap_count", rec_code.size(), 2);
    if (rec_code.size() == 2) begin
      check("tap_first", rec_code[0], 3);
      check("tap_second", rec_code[1], 1);
    end

    // Left held for 40 ticks.
    tick_en = 1'b1;
    wait_phase(2);
    clear_recs();
    set_btns(4'b0010);
    base = tick_cnt;
    hold_until_rel(base, 40);
    cycles(2);
    set_btns(4'b0000);
    cycles(10);
    check("hold40_count", rec_code.size(), 8);
    for (int i = 0; i < rec_code.size() && i < 8; i++) begin
      check($sformatf("hold40_code%0d", i), rec_code[i], 1);
      check($sformatf("hold40_tick%0d", i), rec_tick[i] - base, exp_t40[i]);
    end

    // Rotate, left and down together: ROTATE, LEFT, DOWN with one idle cycle between.
    wait_phase(2);
    clear_recs();
    set_btns(4'b1011);
    c0 = cyc;
    cycles(6);
    set_btns(4'b0000);
    cycles(10);
    check("prio_count_ge3", rec_code.size() >= 3, 1);
    if (rec_code.size() >= 3) begin
      check("prio_0", rec_code[0], 3);
      check("prio_1", rec_code[1], 1);
      check("prio_2", rec_code[2], 0);
      check("prio_lat", rec_cyc[0] - c0, 1);
      check("prio_gap01", rec_cyc[1] - rec_cyc[0], 2);
      check("prio_gap12", rec_cyc[2] - rec_cyc[1], 2);
    end

    // Stall with left repeating: output held, repeats coalesce into one.
    wait_phase(2);
    set_btns(4'b0010);
    base = tick_cnt;
    hold_until_rel(base, 20);
    cmd_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (k >= 10 && !(cmd_valid === 1'b1 && cmd_code === 2'd1)) bad++;
    end
    check("stall_hold_bad_cycles", bad, 0);
    tick_en = 1'b0;
    clear_recs();
    cmd_ready = 1'b1;
    cycles(12);
    check("stall_release_count", rec_code.size(), 2);
    if (rec_code.size() == 2) begin
      check("stall_release_0", rec_code[0], 1);
      check("stall_release_1", rec_code[1], 1);
    end
    set_btns(4'b0000);
    tick_en = 1'b1;
    cycles(10);

    // Left held, right pressed at tick 10.
    wait_phase(2);
    clear_recs();
    set_btns(4'b0010);
    base = tick_cnt;
    hold_until_rel(base, 10);
    set_btns(4'b0110);
    hold_until_rel(base, 30);
    cycles(2);
    set_btns(4'b0000);
    cycles(10);
    check("lr_count", rec_code.size(), 4);
    for (int i = 0; i < rec_code.size() && i < 4; i++) begin
      check($sformatf("lr_code%0d", i), rec_code[i], exp_lr_code[i]);
      check($sformatf("lr_tick%0d", i), rec_tick[i] - base, exp_lr_tick[i]);
    end

    // Reset while a command is stalled.
    cmd_ready = 1'b0;
    set_btns(4'b1000);
    cycles(2);
    check("mid_valid_before", cmd_valid, 1);
    gm_rst_n = 1'b0;
    #1;
    check("mid_valid_async", cmd_valid, 0);
    set_btns(4'b0000);
    @(negedge gm_clk);
    #2;
    cycles(2);
    gm_rst_n = 1'b1;
    cmd_ready = 1'b1;
    clear_recs();
    xfer_total = 0;
    cycles(10);
    check("mid_no_cmd_after", rec_code.size(), 0);

    // Five accepted commands after reset.
    for (int k = 0; k < 5; k++) begin
      set_btns(4'b1000);
      cycle();
      set_btns(4'b0000);
      cycles(3);
    end
    check("post_rst_xfers", rec_code.size(), 5);
`ifdef ARB_STATS_EN
    check("grant_cnt_5", grant_cnt, 5);
    force dut.grant_q = 16'hFFFF;
    cycle();
    release dut.grant_q;
    set_btns(4'b1000);
    cycle();
    set_btns(4'b0000);
    cycles(3);
    check("grant_cnt_sat", grant_cnt, 16'hFFFF);
`else
    check("grant_cnt_tied", grant_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
